// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the fetch, queue and decode stages.
package pipeline_pkg;

    localparam int unsigned PIPE_DATA_WIDTH    = 32;
    localparam int unsigned PIPE_ADDRESS_WIDTH = 32;

    // One fetched instruction together with the PC it was read from.
    typedef struct packed {
        logic [PIPE_ADDRESS_WIDTH-1:0] pc;
        logic [PIPE_DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fetch_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order valid/ready output,
// fetch throttling via fetch_halt, full discard on taken-branch flush.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = PIPE_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = PIPE_ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned HALT_MARGIN   = 2,
    localparam int unsigned COUNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [ADDRESS_WIDTH-1:0] in_pc,
    input  logic                     in_valid,
    output logic                     fetch_halt,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COUNT_W-1:0]       occupancy,
    output logic                     overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               full_c;
    logic               deq_c;
    logic               enq_c;
    logic               drop_c;
    entry_t             wr_entry;
    entry_t             rd_entry;

    // Handshake decode from registered count; nothing here depends on fetch_halt.
    always_comb begin
        full_c = (count == COUNT_W'(DEPTH));
        deq_c  = (count != '0) && out_ready;
        enq_c  = in_valid && !flush && (!full_c || deq_c);
        drop_c = in_valid && !flush && full_c && !deq_c;
    end

    // Pointer, count and sticky overflow state; flush outranks any traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq_c && !deq_c) begin
                count <= count + COUNT_W'(1);
            end else if (deq_c && !enq_c) begin
                count <= count - COUNT_W'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign wr_entry = '{pc: in_pc, instr: in_data};

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (enq_c && rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Head presentation and throttle, all derived from registered state.
    always_comb begin
        out_valid  = (count != '0);
        out_data   = rd_entry.instr;
        out_pc     = rd_entry.pc;
        occupancy  = count;
        fetch_halt = (count >= COUNT_W'(DEPTH - HALT_MARGIN));
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with default parameters (DEPTH=4, HALT_MARGIN=2).
module tb_fetch_queue;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_pc = '0;
    logic          in_valid = 1'b0;
    logic          fetch_halt;
    logic          flush = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_pc;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] occupancy;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_pc      (in_pc),
        .in_valid   (in_valid),
        .fetch_halt (fetch_halt),
        .flush      (flush),
        .out_data   (out_data),
        .out_pc     (out_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for exactly one edge (no checking).
    task automatic push(input logic [AW-1:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = 32'hA000_0000 | pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h99;
        in_data = 32'hDEAD_BEEF;
        tick();
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (fetch_halt !== 1'b0) begin n_err++; $display("FAIL reset_fetch_halt got %b want 0", fetch_halt); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
        in_valid = 1'b1;
        in_pc = 32'h0;
        in_data = 32'h0000_0013;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", out_valid); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL first_pc got %h want 0", out_pc); end
        n_cmp++; if (out_data !== 32'h0000_0013) begin n_err++; $display("FAIL first_data got %h want 00000013", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL first_drain_occ got %0d want 0", occupancy); end
        // Empty with out_ready high must not underflow.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL no_underflow got %0d want 0", occupancy); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push(AW'(i));
            n_cmp++; if (occupancy !== CW'(i + 1)) begin n_err++; $display("FAIL fill_occ[%0d] got %0d want %0d", i, occupancy, i + 1); end
            n_cmp++; if (fetch_halt !== ((i + 1) >= 2)) begin n_err++; $display("FAIL fill_halt[%0d] got %b want %b", i, fetch_halt, (i + 1) >= 2); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow got %b want 0", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_pc !== AW'(i)) begin n_err++; $display("FAIL fill_drain_pc[%0d] got %h want %h", i, out_pc, i); end
            n_cmp++; if (out_data !== (32'hA000_0000 | AW'(i))) begin n_err++; $display("FAIL fill_drain_data[%0d] got %h", i, out_data); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty got %b want 0", out_valid); end
    endtask

    task automatic test_full_traffic();
        for (int i = 0; i < 4; i++) push(AW'(32'h10 + i));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc = AW'(32'h14 + i);
            in_data = 32'hA000_0000 | in_pc;
            n_cmp++; if (out_pc !== AW'(32'h10 + i)) begin n_err++; $display("FAIL pass_head[%0d] got %h want %h", i, out_pc, 32'h10 + i); end
            tick();
            n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL pass_occ[%0d] got %0d want 4", i, occupancy); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_pc !== AW'(32'h13 + i)) begin n_err++; $display("FAIL pass_drain[%0d] got %h want %h", i, out_pc, 32'h13 + i); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pass_empty got %b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pass_overflow got %b want 0", overflow); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push(AW'(32'h30 + i));
        n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL flush_pre_occ got %0d want 3", occupancy); end
        flush = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'h33;
        in_data = 32'hA000_0033;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_cmp++; if (fetch_halt !== 1'b0) begin n_err++; $display("FAIL flush_halt got %b want 0", fetch_halt); end
        push(32'h40);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_flush_valid got %b want 1", out_valid); end
        n_cmp++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL post_flush_pc got %h want 40", out_pc); end
        n_cmp++; if (out_data !== 32'hA000_0040) begin n_err++; $display("FAIL post_flush_data got %h want a0000040", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        while (recv < 10 && cyc < 200) begin
            in_valid = (sent < 10) && !fetch_halt;
            in_pc = AW'(32'h50 + sent);
            in_data = 32'hA000_0000 | in_pc;
            out_ready = (cyc % 2 == 0);
            if (out_valid && out_ready) begin
                n_cmp++; if (out_pc !== AW'(32'h50 + recv)) begin n_err++; $display("FAIL wrap_pc[%0d] got %h want %h", recv, out_pc, 32'h50 + recv); end
                n_cmp++; if (out_data !== (32'hA000_0000 | AW'(32'h50 + recv))) begin n_err++; $display("FAIL wrap_data[%0d] got %h", recv, out_data); end
                recv++;
            end
            if (in_valid) sent++;
            tick();
            cyc++;
            n_cmp++; if (occupancy > 3'd4) begin n_err++; $display("FAIL wrap_occ got %0d want <=4", occupancy); end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (recv !== 10) begin n_err++; $display("FAIL wrap_timeout got %0d words want 10", recv); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push(AW'(32'h20 + i));
        push(32'h2F);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL ovf_occ got %0d want 4", occupancy); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_pc !== AW'(32'h20 + i)) begin n_err++; $display("FAIL ovf_drain[%0d] got %h want %h", i, out_pc, 32'h20 + i); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped got valid %b want 0", out_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_traffic();
        test_flush();
        test_wrap();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
